// File: rtl/mux_scan_pkg.sv
// Shared constants for the 8:1 MUX scanner: FSM state encoding and channel geometry.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Combinational search for the next set channel above the current select.
// With i_from_start=1 the current select is ignored, so the lowest set channel is returned.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_cur,
  input  logic              i_from_start,
  output logic [SEL_W-1:0]  o_next,
  output logic              o_last
);

  // Descending walk so the lowest qualifying channel is the final assignment.
  always_comb begin
    o_next = '0;
    o_last = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_from_start || (i > int'(i_cur)))) begin
        o_next = SEL_W'(i);
        o_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_8_1_scanner.sv
// Scans a masked set of 8:1 MUX channels, dwelling on each, and hands the captured frame
// downstream over valid/ready. Optional Parity_Out when MUX_SCAN_PARITY_EN is defined.
module mux_8_1_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              Clock_In,
  input  logic              Reset_n_In,
  input  logic              Start_In,
  input  logic              Continuous_In,
  input  logic [NUM_CH-1:0] Channel_Mask_In,
  input  logic              MUX_Data_In,
  output logic [SEL_W-1:0]  Select_Out,
  output logic              Enable_Out,
  output logic [NUM_CH-1:0] Sample_Data_Out,
  output logic              Sample_Valid_Out,
  input  logic              Sample_Ready_In,
  output logic              Busy_Out
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic              Parity_Out
`endif
);

  localparam logic [CNT_W-1:0] Reload = CNT_W'(DWELL_CYCLES - 1);

  logic [1:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic [NUM_CH-1:0] r_shadow, w_shadow_nxt;
  logic [SEL_W-1:0]  r_sel, w_sel_nxt;
  logic              r_en, w_en_nxt;
  logic [NUM_CH-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_busy;

  logic [NUM_CH-1:0] w_scan_mask;
  logic              w_from_start;
  logic [SEL_W-1:0]  w_next_ch;
  logic              w_last;
  logic [NUM_CH-1:0] w_capture;
  logic              w_mask_nz;

  // Outside SETTLE the search runs on the live mask to find the first channel of a new scan.
  assign w_scan_mask  = (r_state == SETTLE) ? r_mask : Channel_Mask_In;
  assign w_from_start = (r_state != SETTLE);
  assign w_mask_nz    = |Channel_Mask_In;
  assign w_capture    = r_shadow | (NUM_CH'(MUX_Data_In) << r_sel);

  mux_scan_next_ch u_next_ch (
    .i_mask       (w_scan_mask),
    .i_cur        (r_sel),
    .i_from_start (w_from_start),
    .o_next       (w_next_ch),
    .o_last       (w_last)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mask_nxt   = r_mask;
    w_shadow_nxt = r_shadow;
    w_sel_nxt    = r_sel;
    w_en_nxt     = r_en;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid;
    unique case (r_state)
      IDLE: begin
        if (Start_In && w_mask_nz) begin
          w_mask_nxt   = Channel_Mask_In;
          w_shadow_nxt = '0;
          w_sel_nxt    = w_next_ch;
          w_en_nxt     = 1'b1;
          w_cnt_nxt    = Reload;
          w_state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_shadow_nxt = w_capture;
          if (!w_last) begin
            w_sel_nxt = w_next_ch;
            w_cnt_nxt = Reload;
          end else begin
            w_en_nxt    = 1'b0;
            w_data_nxt  = w_capture;
            w_valid_nxt = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (Sample_Ready_In) begin
          w_valid_nxt = 1'b0;
          if (Continuous_In && w_mask_nz) begin
            w_mask_nxt   = Channel_Mask_In;
            w_shadow_nxt = '0;
            w_sel_nxt    = w_next_ch;
            w_en_nxt     = 1'b1;
            w_cnt_nxt    = Reload;
            w_state_nxt  = SETTLE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_en_nxt    = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
      r_sel    <= '0;
      r_en     <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mask   <= w_mask_nxt;
      r_shadow <= w_shadow_nxt;
      r_sel    <= w_sel_nxt;
      r_en     <= w_en_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= (w_state_nxt != IDLE);
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_parity;

  // Parity of the held frame equals parity of the new frame whenever the frame updates.
  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_data_nxt;
    end
  end

  assign Parity_Out = r_parity;
`endif

  assign Select_Out       = r_sel;
  assign Enable_Out       = r_en;
  assign Sample_Data_Out  = r_data;
  assign Sample_Valid_Out = r_valid;
  assign Busy_Out         = r_busy;

endmodule

// File: tb/tb_mux_8_1_scanner.sv
// Self-checking bench for mux_8_1_scanner: table vectors, random scans against a frame model,
// and hand sequences for reset, backpressure and continuous mode.
module tb_mux_8_1_scanner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cont;
  logic [7:0] mask;
  logic       mux_data;
  logic [2:0] sel;
  logic       en;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;
`endif

  logic [7:0] pattern;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // Behavioural 8:1 MUX: tristated (read as 0) while disabled.
  assign mux_data = en ? pattern[sel] : 1'b0;

  mux_8_1_scanner #(
    .DWELL_CYCLES (D),
    .CNT_W        (8)
  ) dut (
    .Clock_In         (clk),
    .Reset_n_In       (rst_n),
    .Start_In         (start),
    .Continuous_In    (cont),
    .Channel_Mask_In  (mask),
    .MUX_Data_In      (mux_data),
    .Select_Out       (sel),
    .Enable_Out       (en),
    .Sample_Data_Out  (data),
    .Sample_Valid_Out (valid),
    .Sample_Ready_In  (ready),
    .Busy_Out         (busy)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .Parity_Out       (parity)
`endif
  );

  typedef struct {
    logic [7:0] vmask;
    logic [7:0] vpat;
    bit         pulse;
    logic [7:0] exp_frame;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan from a start request until valid; checks select schedule, latency, frame, handshake.
  task automatic run_scan(input logic [7:0] m, input logic [7:0] pat, input bit pulse,
                          input logic [7:0] exp_frame, input int exp_lat, input bit hs);
    int chs[$];
    int seq_err = 0;
    int k;
    for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(i);
    pattern = pat;
    @(negedge clk);
    start = 1'b1;
    mask  = m;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 400 && valid !== 1'b1; k++) begin
      if (k / D < chs.size()) begin
        if (en !== 1'b1 || int'(sel) != chs[k / D] || busy !== 1'b1) seq_err++;
      end else begin
        seq_err++;
      end
      start = pulse && (k == 5 || k == 9);
      mask  = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("seq", seq_err, 0);
    check("latency", k, exp_lat);
    check("frame", int'(data), int'(exp_frame));
    check("en_off_done", int'(en), 0);
`ifdef MUX_SCAN_PARITY_EN
    check("parity", int'(parity), int'(^exp_frame));
`endif
    if (hs) begin
      @(negedge clk);
      check("valid_drop", int'(valid), 0);
      check("busy_idle", int'(busy), 0);
      check("frame_held", int'(data), int'(exp_frame));
    end
  endtask

  function automatic logic [7:0] model_frame(input logic [7:0] m, input logic [7:0] pat);
    logic [7:0] f = '0;
    for (int i = 0; i < 8; i++) if (m[i]) f[i] = pat[i];
    return f;
  endfunction

  function automatic int model_lat(input logic [7:0] m);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m[i]);
    return n * D;
  endfunction

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hFF, 8'hA5, 1'b0, 8'hA5, 32};
    vecs[1] = '{8'h92, 8'hFF, 1'b0, 8'h92, 12};
    vecs[2] = '{8'h07, 8'hFF, 1'b1, 8'h07, 12};
    vecs[3] = '{8'h01, 8'hFF, 1'b0, 8'h01, 4};
    vecs[4] = '{8'h80, 8'h00, 1'b0, 8'h00, 4};
    vecs[5] = '{8'h3C, 8'hC3, 1'b1, 8'h00, 16};

    rst_n   = 1'b0;
    start   = 1'b0;
    cont    = 1'b0;
    mask    = 8'h00;
    ready   = 1'b1;
    pattern = 8'h00;
    #23;
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_sel", int'(sel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start with an empty mask must not leave IDLE.
    @(negedge clk);
    start = 1'b1;
    mask  = 8'h00;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("zero_mask_busy", int'(busy), 0);
    check("zero_mask_en", int'(en), 0);

    for (int i = 0; i < 6; i++)
      run_scan(vecs[i].vmask, vecs[i].vpat, vecs[i].pulse, vecs[i].exp_frame, vecs[i].exp_lat,
               1'b1);

    for (int i = 0; i < 8; i++) begin
      logic [7:0] m;
      logic [7:0] p;
      m = 8'($urandom_range(1, 255));
      p = 8'($urandom);
      run_scan(m, p, 1'b0, model_frame(m, p), model_lat(m), 1'b1);
    end

    // Backpressure: frame and valid held while Ready is low.
    ready = 1'b0;
    run_scan(8'h92, 8'h6D, 1'b0, model_frame(8'h92, 8'h6D), model_lat(8'h92), 1'b0);
    begin
      int hold_err = 0;
      repeat (20) begin
        @(negedge clk);
        if (valid !== 1'b1 || data !== model_frame(8'h92, 8'h6D) || en !== 1'b0 ||
            busy !== 1'b1) hold_err++;
      end
      check("bp_hold", hold_err, 0);
    end
    ready = 1'b1;
    @(negedge clk);
    check("bp_release", int'(valid), 0);

    // Continuous mode: mask changes mid-scan take effect only at the handshake edge.
    cont    = 1'b1;
    pattern = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    mask  = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) mask = 8'hF0;
      @(negedge clk);
    end
    check("cont_valid1", int'(valid), 1);
    check("cont_frame1", int'(data), int'(model_frame(8'h0F, 8'h5A)));
    @(negedge clk);
    check("cont_restart_valid", int'(valid), 0);
    check("cont_restart_en", int'(en), 1);
    check("cont_restart_sel", int'(sel), 4);
    check("cont_restart_busy", int'(busy), 1);
    mask = 8'h00;
    repeat (16) @(negedge clk);
    check("cont_valid2", int'(valid), 1);
    check("cont_frame2", int'(data), int'(model_frame(8'hF0, 8'h5A)));
    @(negedge clk);
    check("cont_stop_busy", int'(busy), 0);
    check("cont_stop_en", int'(en), 0);
    cont = 1'b0;

    // Asynchronous reset mid-scan discards everything immediately.
    pattern = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    mask  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", int'(en), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_data", int'(data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_en", int'(en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
